// File: rtl/sprite_mem_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_mem_arbiter
//
// Shares one synchronous sprite/background ROM among the pixel-colour
// requesters (0 = background, 1 = ball, 2 = basket by default). Each cycle at
// most one requester is granted. Its address is registered onto the ROM port,
// and the ROM data is handed back a fixed number of cycles later. A one-hot
// valid names the owner of the returned data.
//
// Handshake: req[i] is a valid and gnt[i] is the matching ready. A transfer
// happens in any cycle where both are high. Until it sees gnt[i], a requester
// keeps req[i] and its address slice stable. It may hold req[i] high across
// consecutive cycles to issue back-to-back reads. gnt is combinational from
// req, so a requester can respond to it within the same cycle.
//
// Configuration macro: SPRITE_ARB_FIXED_PRIO_EN
//   undefined (default) : round-robin arbitration with a rotating pointer
//   defined             : fixed priority, the lowest requesting index wins and
//                         the pointer stays at 0 (debug builds; sprites can
//                         be starved by the background)
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   ADDR_W   ROM address width
//   DATA_W   ROM data / colour width
//   ROM_LAT  ROM latency, mem_rd sampled -> mem_data valid (1..4)
//
// Ports:
//   Clk       in   system clock, rising edge
//   Reset_h   in   synchronous active-high reset
//   req       in   per-requester read request
//   addr      in   per-requester address, requester i at [i*ADDR_W +: ADDR_W]
//   gnt       out  one-hot grant (combinational), forced to 0 in reset
//   mem_rd    out  ROM read strobe (registered)
//   mem_addr  out  ROM address (registered, holds between reads)
//   mem_data  in   ROM read data, valid ROM_LAT cycles after mem_rd
//   rdata     out  returned data (registered, holds when no return)
//   rvalid    out  one-hot owner of rdata, single-cycle pulse (registered)
//   busy      out  high while any read is in flight or being returned
// -----------------------------------------------------------------------------
module sprite_mem_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int ROM_LAT = 2
) (
    input  logic                      Clk,
    input  logic                      Reset_h,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      mem_rd,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_data,
    output logic [DATA_W-1:0]         rdata,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic                      busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               mem_rd_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [NUM_REQ-1:0] rvalid_q;

    // Owner tags travel with each read. Stage 0 is loaded on the transfer
    // cycle, and stage ROM_LAT lines up with mem_data being valid.
    logic [NUM_REQ-1:0] tag_q [ROM_LAT+1];

    logic [NUM_REQ-1:0] gnt_d;
    logic [ADDR_W-1:0]  gnt_addr;
    logic               tag_any;

    // -------------------------------------------------------------------------
    // Grant selection
    // -------------------------------------------------------------------------
`ifdef SPRITE_ARB_FIXED_PRIO_EN
    // Fixed priority: lowest requesting index wins, pointer pinned at 0.
    logic fp_found;

    always_comb begin
        gnt_d    = '0;
        ptr_d    = '0;
        fp_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!fp_found && req[i]) begin
                gnt_d[i] = 1'b1;
                fp_found = 1'b1;
            end
        end
        if (Reset_h) begin
            gnt_d = '0;
        end
    end
`else
    // Round-robin: search ptr, ptr+1, ... modulo NUM_REQ. The sum is one bit
    // wider than the pointer so the wrap test works for non-power-of-two
    // requester counts.
    logic [PTR_W:0]   rr_sum;
    logic [PTR_W-1:0] rr_idx;
    logic             rr_found;

    always_comb begin
        gnt_d    = '0;
        ptr_d    = ptr_q;
        rr_sum   = '0;
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (rr_sum >= (PTR_W+1)'(NUM_REQ)) begin
                rr_sum = rr_sum - (PTR_W+1)'(NUM_REQ);
            end
            rr_idx = rr_sum[PTR_W-1:0];
            if (!rr_found && req[rr_idx]) begin
                rr_found      = 1'b1;
                gnt_d[rr_idx] = 1'b1;
                // The winner drops to the lowest priority next cycle.
                if (rr_idx == PTR_W'(NUM_REQ-1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = rr_idx + 1'b1;
                end
            end
        end
        if (Reset_h) begin
            gnt_d = '0;
        end
    end
`endif

    // Address of the granted requester. Because gnt is one-hot, an OR of the
    // masked slices acts as a mux.
    always_comb begin
        gnt_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_d[i]) begin
                gnt_addr = gnt_addr | addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // -------------------------------------------------------------------------
    // ROM port, tag pipeline and return path
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            ptr_q      <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            rdata_q    <= '0;
            rvalid_q   <= '0;
            // Clearing the tags discards every in-flight read, so no return
            // pulse can escape after reset.
            for (int s = 0; s <= ROM_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            mem_rd_q <= |gnt_d;
            if (|gnt_d) begin
                mem_addr_q <= gnt_addr;
            end
            tag_q[0] <= gnt_d;
            for (int s = 1; s <= ROM_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
            rvalid_q <= tag_q[ROM_LAT];
            if (|tag_q[ROM_LAT]) begin
                rdata_q <= mem_data;
            end
        end
    end

    // busy covers the strobe, every tag stage and the return register. The
    // return register is included so that busy falls the cycle after the
    // final rvalid pulse rather than during it.
    always_comb begin
        tag_any = 1'b0;
        for (int s = 0; s <= ROM_LAT; s++) begin
            tag_any = tag_any | (|tag_q[s]);
        end
    end

    assign gnt      = gnt_d;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign busy     = mem_rd_q | tag_any | (|rvalid_q);

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Directed bench for sprite_mem_arbiter at default parameters (3 requesters,
// 16-bit address/data, ROM latency 2). Inputs change 1 ns after a rising
// edge, and outputs are checked 1-2 ns later, well away from the next edge.
module tb_sprite_mem_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int ROM_LAT = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic                      clk;
  logic                      reset_h;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0]        gnt;
  logic                      mem_rd;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_data;
  logic [DATA_W-1:0]         rdata;
  logic [NUM_REQ-1:0]        rvalid;
  logic                      busy;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  sprite_mem_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .ROM_LAT (ROM_LAT)
  ) dut (
    .Clk      (clk),
    .Reset_h  (reset_h),
    .req      (req),
    .addr     (addr),
    .gnt      (gnt),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .busy     (busy)
  );

  // ---------------------------------------------------------------------------
  // ROM model: two-cycle synchronous read. Address 0x0123 holds 16'hF800.
  // Every other address holds its byte-swapped value XOR 16'h5A5A.
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
    if (a == 16'h0123) return 16'hF800;
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  logic [ADDR_W-1:0] rom_p1 = '0;
  logic [ADDR_W-1:0] rom_p2 = '0;

  always @(posedge clk) begin
    rom_p1 <= mem_addr;
    rom_p2 <= rom_p1;
  end

  assign mem_data = rom_f(rom_p2);

  // ---------------------------------------------------------------------------
  // Scoreboard counters and driver tasks
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
    addr[i*ADDR_W +: ADDR_W] = a;
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] rr_seq [3];
  logic [DATA_W-1:0]  b2b_data [3];
  logic [NUM_REQ-1:0] exp_g;

  initial begin
    rr_seq[0]   = 3'b001;
    rr_seq[1]   = 3'b010;
    rr_seq[2]   = 3'b100;
    b2b_data[0] = 16'h4A5A;   // rom(0x10)
    b2b_data[1] = 16'h4B5A;   // rom(0x11)
    b2b_data[2] = 16'h485A;   // rom(0x12)

    reset_h = 1'b1;
    req     = '0;
    addr    = '0;
    repeat (2) next_cycle();

    // ---- Reset state: grant suppressed even with every request up ----
    req = 3'b111;
    #1;
    chk("reset_gnt",      32'(gnt),      32'h0);
    chk("reset_mem_rd",   32'(mem_rd),   32'h0);
    chk("reset_mem_addr", 32'(mem_addr), 32'h0);
    chk("reset_rdata",    32'(rdata),    32'h0);
    chk("reset_rvalid",   32'(rvalid),   32'h0);
    chk("reset_busy",     32'(busy),     32'h0);
    next_cycle();
    reset_h = 1'b0;
    req     = '0;
    #1;
    chk("noreq_gnt", 32'(gnt), 32'h0);

    // ---- Single read by the ball unit ----
    req = 3'b010;
    set_addr(1, 16'h0123);
    #1;
    chk("single_gnt", 32'(gnt), 32'h2);
    next_cycle();
    req = '0;
    #1;
    chk("single_mem_rd",   32'(mem_rd),   32'h1);
    chk("single_mem_addr", 32'(mem_addr), 32'h0123);
    chk("single_busy",     32'(busy),     32'h1);
    repeat (3) next_cycle();
    chk("single_rvalid", 32'(rvalid), 32'h2);
    chk("single_rdata",  32'(rdata),  32'hF800);
    chk("single_busy_ret", 32'(busy), 32'h1);
    next_cycle();
    chk("single_rvalid_end", 32'(rvalid), 32'h0);
    chk("single_rdata_hold", 32'(rdata),  32'hF800);
    chk("single_busy_end",   32'(busy),   32'h0);

    // ---- Pointer wrap: pointer sits at 2 after the ball read ----
    req = 3'b100;
    set_addr(2, 16'h0030);
    #1;
    chk("wrap_gnt2", 32'(gnt), 32'h4);
    next_cycle();
    req = 3'b101;
    set_addr(0, 16'h0031);
    #1;
    chk("wrap_gnt0", 32'(gnt), 32'h1);
    next_cycle();
`ifdef SPRITE_ARB_FIXED_PRIO_EN
    exp_g = 3'b001;
`else
    exp_g = 3'b100;
`endif
    #1;
    chk("wrap_gnt_next", 32'(gnt), 32'(exp_g));
    next_cycle();
    req = '0;
    repeat (6) next_cycle();

    // ---- Full contention for 9 cycles ----
    req = 3'b111;
    for (int k = 0; k < 9; k++) begin
`ifdef SPRITE_ARB_FIXED_PRIO_EN
      exp_g = 3'b001;
`else
      exp_g = rr_seq[k % 3];
`endif
      #1;
      chk($sformatf("contend_gnt[%0d]", k), 32'(gnt), 32'(exp_g));
      next_cycle();
    end
    req = '0;
    repeat (6) next_cycle();

    // ---- Back-to-back reads by the basket unit ----
    for (int j = 0; j < 8; j++) begin
      req = (j < 3) ? 3'b100 : 3'b000;
      set_addr(2, 16'(16'h0010 + j));
      #1;
      if (j < 3) chk($sformatf("b2b_gnt[%0d]", j), 32'(gnt), 32'h4);
      chk($sformatf("b2b_busy[%0d]", j), 32'(busy), (j >= 1 && j <= 6) ? 32'h1 : 32'h0);
      chk($sformatf("b2b_mem_rd[%0d]", j), 32'(mem_rd), (j >= 1 && j <= 3) ? 32'h1 : 32'h0);
      if (j >= 1 && j <= 3)
        chk($sformatf("b2b_mem_addr[%0d]", j), 32'(mem_addr), 32'(16'h0010 + j - 1));
      chk($sformatf("b2b_rvalid[%0d]", j), 32'(rvalid), (j >= 4 && j <= 6) ? 32'h4 : 32'h0);
      if (j >= 4 && j <= 6)
        chk($sformatf("b2b_rdata[%0d]", j), 32'(rdata), 32'(b2b_data[j-4]));
      next_cycle();
    end

    // ---- Reset mid-flight ----
    req = 3'b001;
    set_addr(0, 16'h0020);
    #1;
    chk("rst_gnt_a", 32'(gnt), 32'h1);
    next_cycle();
    req = 3'b010;
    set_addr(1, 16'h0021);
    #1;
    chk("rst_gnt_b", 32'(gnt), 32'h2);
    next_cycle();
    reset_h = 1'b1;
    req     = 3'b111;
    #1;
    chk("rst_gnt_forced", 32'(gnt), 32'h0);
    next_cycle();
    reset_h = 1'b0;
    #1;
    chk("rst_mem_rd",   32'(mem_rd),   32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_rdata",    32'(rdata),    32'h0);
    chk("rst_rvalid",   32'(rvalid),   32'h0);
    chk("rst_busy",     32'(busy),     32'h0);
    chk("rst_ptr_gnt",  32'(gnt),      32'h1);
    next_cycle();
    req = '0;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk($sformatf("rst_no_rvalid[%0d]", j), 32'(rvalid), 32'h0);
      chk($sformatf("rst_rdata_zero[%0d]", j), 32'(rdata), 32'h0);
      next_cycle();
    end
    chk("rst_new_rvalid", 32'(rvalid), 32'h1);
    chk("rst_new_rdata",  32'(rdata),  32'h7A5A);
    next_cycle();

    // ---- Idle ----
    req = '0;
    for (int j = 0; j < 20; j++) begin
      #1;
      chk($sformatf("idle_gnt[%0d]", j),    32'(gnt),    32'h0);
      chk($sformatf("idle_mem_rd[%0d]", j), 32'(mem_rd), 32'h0);
      chk($sformatf("idle_rvalid[%0d]", j), 32'(rvalid), 32'h0);
      chk($sformatf("idle_busy[%0d]", j),   32'(busy),   32'h0);
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
